// File: rtl/prep3_pkg.sv
// Shared definitions for the prep3 code tracker: shadow state encoding,
// the FSM output codes, path tags and the record layout.
package prep3_pkg;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_SA    = 3'd1,
        ST_SB    = 3'd2,
        ST_SC    = 3'd3,
        ST_SD    = 3'd4,
        ST_SE    = 3'd5,
        ST_SF    = 3'd6,
        ST_SG    = 3'd7
    } state_e;

    localparam logic [7:0] CODE_IDLE      = 8'h00;
    localparam logic [7:0] CODE_GO        = 8'h82;
    localparam logic [7:0] CODE_SA_HOLD   = 8'h04;
    localparam logic [7:0] CODE_SA_TO_SC  = 8'h40;
    localparam logic [7:0] CODE_SA_TO_SB  = 8'h20;
    localparam logic [7:0] CODE_SB_TO_SE  = 8'h11;
    localparam logic [7:0] CODE_SB_TO_SF  = 8'h30;
    localparam logic [7:0] CODE_SC_TO_SD  = 8'h08;
    localparam logic [7:0] CODE_SD_TO_SG  = 8'h80;
    localparam logic [7:0] CODE_SF_TO_SG  = 8'h02;
    localparam logic [7:0] CODE_SE_EXIT   = 8'h40;
    localparam logic [7:0] CODE_SG_EXIT   = 8'h01;

    localparam logic [1:0] PATH_SC  = 2'd0;
    localparam logic [1:0] PATH_SE  = 2'd1;
    localparam logic [1:0] PATH_SF  = 2'd2;
    localparam logic [1:0] PATH_ERR = 2'd3;

    localparam int unsigned REC_W   = 8;
    localparam logic [4:0]  LEN_MAX = 5'd31;

    // Record byte: {err, path, len}
    function automatic logic [REC_W-1:0] make_rec(input logic       err,
                                                  input logic [1:0] path,
                                                  input logic [4:0] len);
        return {err, path, len};
    endfunction

endpackage

// File: rtl/rec_fifo.sv
// Synchronous record FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate count.
module rec_fifo
    import prep3_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = REC_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is still taken when the head leaves this cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_data = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/prep3_code_tracker.sv
// Shadow of the prep3 FSM rebuilt from its output codes; emits one record
// per completed or aborted frame into a small FIFO and keeps counters.
module prep3_code_tracker
    import prep3_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       code_in,
    input  logic             code_valid,
    output logic [7:0]       rec_data,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [2:0]       shadow_state,
    output logic             sync_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [7:0]       err_cnt,
    output logic [7:0]       drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           r_state;
    logic [4:0]       r_len;
    logic [1:0]       r_path;
    logic             r_sync_err;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [7:0]       r_err_cnt;
    logic [7:0]       r_drop_cnt;

    state_e           w_next_state;
    logic             w_legal;
    logic             w_idle;
    logic             w_go;
    logic             w_complete;
    logic             w_path_set;
    logic [1:0]       w_path_val;
    logic [4:0]       w_len_inc;
    logic             w_push;
    logic [REC_W-1:0] w_rec;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_drop;

    always_comb begin
        w_next_state = ST_START;
        w_legal      = 1'b0;
        w_idle       = 1'b0;
        w_go         = 1'b0;
        w_complete   = 1'b0;
        w_path_set   = 1'b0;
        w_path_val   = r_path;
        unique case (r_state)
            ST_START: begin
                if (code_in == CODE_IDLE) begin
                    w_legal = 1'b1;
                    w_idle  = 1'b1;
                end else if (code_in == CODE_GO) begin
                    w_legal      = 1'b1;
                    w_go         = 1'b1;
                    w_next_state = ST_SA;
                end
            end
            ST_SA: begin
                if (code_in == CODE_SA_HOLD) begin
                    w_legal      = 1'b1;
                    w_next_state = ST_SA;
                end else if (code_in == CODE_SA_TO_SC) begin
                    w_legal      = 1'b1;
                    w_next_state = ST_SC;
                    w_path_set   = 1'b1;
                    w_path_val   = PATH_SC;
                end else if (code_in == CODE_SA_TO_SB) begin
                    w_legal      = 1'b1;
                    w_next_state = ST_SB;
                end
            end
            ST_SB: begin
                if (code_in == CODE_SB_TO_SE) begin
                    w_legal      = 1'b1;
                    w_next_state = ST_SE;
                    w_path_set   = 1'b1;
                    w_path_val   = PATH_SE;
                end else if (code_in == CODE_SB_TO_SF) begin
                    w_legal      = 1'b1;
                    w_next_state = ST_SF;
                    w_path_set   = 1'b1;
                    w_path_val   = PATH_SF;
                end
            end
            ST_SC: begin
                if (code_in == CODE_SC_TO_SD) begin
                    w_legal      = 1'b1;
                    w_next_state = ST_SD;
                end
            end
            ST_SD: begin
                if (code_in == CODE_SD_TO_SG) begin
                    w_legal      = 1'b1;
                    w_next_state = ST_SG;
                end
            end
            ST_SF: begin
                if (code_in == CODE_SF_TO_SG) begin
                    w_legal      = 1'b1;
                    w_next_state = ST_SG;
                end
            end
            ST_SE: begin
                if (code_in == CODE_SE_EXIT) begin
                    w_legal    = 1'b1;
                    w_complete = 1'b1;
                end
            end
            ST_SG: begin
                if (code_in == CODE_SG_EXIT) begin
                    w_legal    = 1'b1;
                    w_complete = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // len is always 0 in START, so an illegal code there records len=1
    assign w_len_inc = (r_len == LEN_MAX) ? r_len : r_len + 5'd1;
    assign w_push    = code_valid && (w_complete || !w_legal);
    assign w_rec     = w_legal ? make_rec(1'b0, r_path, w_len_inc)
                               : make_rec(1'b1, PATH_ERR, w_len_inc);
    assign w_pop     = !w_empty && rec_ready;
    assign w_drop    = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_START;
            r_len       <= '0;
            r_path      <= PATH_SC;
            r_sync_err  <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_sync_err <= code_valid && !w_legal;
            if (code_valid) begin
                r_state <= w_next_state;
                if (!w_legal || w_complete || w_idle) begin
                    r_len <= '0;
                end else if (w_go) begin
                    r_len <= 5'd1;
                end else begin
                    r_len <= w_len_inc;
                end
                if (w_go) begin
                    r_path <= PATH_SC;
                end else if (w_path_set) begin
                    r_path <= w_path_val;
                end
                if (w_complete) begin
                    r_frame_cnt <= r_frame_cnt + CNT_ONE;
                end
                if (!w_legal && r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
            if (w_drop && r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    rec_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_rec_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (w_push),
        .i_data  (w_rec),
        .i_pop   (w_pop),
        .o_data  (rec_data),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign rec_valid    = !w_empty;
    assign shadow_state = r_state;
    assign sync_err     = r_sync_err;
    assign frame_cnt    = r_frame_cnt;
    assign err_cnt      = r_err_cnt;
    assign drop_cnt     = r_drop_cnt;

endmodule
